// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
//   ps2_state_t : frame FSM states
//   ps2_entry_t : decoded key as stored in the FIFO {ext, brk, code}
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

   localparam int unsigned PS2_ENTRY_W = $bits(ps2_entry_t);

endpackage

// File: rtl/ps2_code_fifo.sv
// Synchronous show-ahead FIFO for decoded scan codes.
//   i_wr_en/i_wr_data : push request (dropped when full unless popping too)
//   i_rd_en           : pop head (ignored when empty)
//   o_rd_data         : head entry, 0 when empty
//   o_valid/o_count   : not-empty flag and occupancy
//   o_overflow        : one-cycle pulse when a push is dropped
module ps2_code_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_rd_en && (r_count != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push  = i_wr_en && (!w_full || w_pop);

   assign o_valid   = (r_count != '0);
   assign o_count   = r_count;
   assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= i_wr_en && w_full && !w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit
// frames, checks parity/stop bit, folds E0/F0 prefixes into ext/brk flags and
// queues decoded keys in a show-ahead FIFO.
//   clk, rst            : system clock, async active-high reset
//   PS2_clk, PS2_DAT    : raw PS/2 pins
//   rd_en               : pop FIFO head
//   valid/code/ext/brk  : FIFO head (zero when empty)
//   count               : FIFO occupancy
//   last_code           : most recent non-prefix code accepted
//   parity_err, frame_err, overflow : one-cycle error pulses
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter bit          CHECK_PARITY   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          PS2_clk,
   input  logic                          PS2_DAT,
   input  logic                          rd_en,
   output logic                          valid,
   output logic [7:0]                    code,
   output logic                          ext,
   output logic                          brk,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [7:0]                    last_code,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int unsigned    TW     = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_clk_s;
   logic                   w_dat_s;
   logic                   w_fall;

   ps2_state_t             r_state;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shreg;
   logic                   r_par;
   logic                   r_ext_pend;
   logic                   r_brk_pend;
   logic [TW-1:0]          r_to_cnt;
   logic                   r_push;
   ps2_entry_t             r_push_entry;
   logic                   w_par_ok;
   logic [PS2_ENTRY_W-1:0] w_head;
   ps2_entry_t             w_head_e;

   assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
   assign w_fall   = r_clk_prev && !w_clk_s;
   assign w_par_ok = !CHECK_PARITY || (^{r_shreg, r_par} == 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
         r_clk_prev <= w_clk_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_shreg      <= '0;
         r_par        <= 1'b0;
         r_ext_pend   <= 1'b0;
         r_brk_pend   <= 1'b0;
         r_to_cnt     <= '0;
         r_push       <= 1'b0;
         r_push_entry <= '0;
         last_code    <= '0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         r_push     <= 1'b0;

         if (r_state == IDLE || w_fall) r_to_cnt <= '0;
         else                           r_to_cnt <= r_to_cnt + 1'b1;

         if (w_fall) begin
            case (r_state)
               IDLE: begin
                  if (!w_dat_s) begin
                     r_state   <= DATA;
                     r_bit_cnt <= '0;
                     r_shreg   <= '0;
                  end
               end
               DATA: begin
                  r_shreg[r_bit_cnt] <= w_dat_s;
                  r_bit_cnt          <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= PARITY;
               end
               PARITY: begin
                  r_par   <= w_dat_s;
                  r_state <= STOP;
               end
               STOP: begin
                  r_state <= IDLE;
                  if (!w_dat_s) begin
                     frame_err  <= 1'b1;
                     r_ext_pend <= 1'b0;
                     r_brk_pend <= 1'b0;
                  end else if (!w_par_ok) begin
                     parity_err <= 1'b1;
                     r_ext_pend <= 1'b0;
                     r_brk_pend <= 1'b0;
                  end else if (r_shreg == PS2_EXT_PREFIX) begin
                     r_ext_pend <= 1'b1;
                  end else if (r_shreg == PS2_BRK_PREFIX) begin
                     r_brk_pend <= 1'b1;
                  end else begin
                     r_push            <= 1'b1;
                     r_push_entry.ext  <= r_ext_pend;
                     r_push_entry.brk  <= r_brk_pend;
                     r_push_entry.code <= r_shreg;
                     last_code         <= r_shreg;
                     r_ext_pend        <= 1'b0;
                     r_brk_pend        <= 1'b0;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end else if (r_state != IDLE && r_to_cnt == TO_MAX) begin
            // Abandon the frame but keep prefixes already seen.
            r_state   <= IDLE;
            frame_err <= 1'b1;
         end
      end
   end

   ps2_code_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (r_push),
      .i_wr_data  (r_push_entry),
      .i_rd_en    (rd_en),
      .o_rd_data  (w_head),
      .o_valid    (valid),
      .o_count    (count),
      .o_overflow (overflow)
   );

   assign w_head_e = ps2_entry_t'(w_head);
   assign code     = w_head_e.code;
   assign ext      = w_head_e.ext;
   assign brk      = w_head_e.brk;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver. A second instance with parity checking
// disabled shares the PS/2 lines and reset.
module tb_ps2_scan_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic       rd_en = 1'b0;

   logic       valid, ext, brk, parity_err, frame_err, overflow;
   logic [7:0] code, last_code;
   logic [3:0] count;

   logic       np_valid, np_ext, np_brk, np_pe, np_fe, np_ov;
   logic [7:0] np_code, np_last;
   logic [3:0] np_count;

   int n_pass = 0;
   int n_total = 0;
   int pe_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   always #5 clk = ~clk;

   ps2_scan_receiver #(
      .SYNC_STAGES(2), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(200), .CHECK_PARITY(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .PS2_clk(ps2c), .PS2_DAT(ps2d), .rd_en(rd_en),
      .valid(valid), .code(code), .ext(ext), .brk(brk), .count(count),
      .last_code(last_code), .parity_err(parity_err), .frame_err(frame_err),
      .overflow(overflow)
   );

   ps2_scan_receiver #(
      .SYNC_STAGES(2), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(200), .CHECK_PARITY(1'b0)
   ) dut_np (
      .clk(clk), .rst(rst), .PS2_clk(ps2c), .PS2_DAT(ps2d), .rd_en(1'b0),
      .valid(np_valid), .code(np_code), .ext(np_ext), .brk(np_brk), .count(np_count),
      .last_code(np_last), .parity_err(np_pe), .frame_err(np_fe), .overflow(np_ov)
   );

   // Pulse counters: a one-cycle pulse adds exactly 1.
   always @(negedge clk) begin
      if (parity_err) pe_cnt++;
      if (frame_err)  fe_cnt++;
      if (overflow)   ov_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   // One PS/2 bit: 16 clk cycles. With pop set, rd_en is raised for the cycle in
   // which the stop-bit push reaches the FIFO (2 sync stages + 1 evaluate cycle).
   task automatic send_bit(input logic v, input bit pop);
      ps2d = v;
      tick(4);
      ps2c = 1'b0;
      if (pop) begin
         tick(3);
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
         tick(4);
      end else begin
         tick(8);
      end
      ps2c = 1'b1;
      tick(4);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop);
      logic [10:0] fr;
      fr = {stp, par, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(fr[i], pop && (i == 10));
      ps2d = 1'b1;
      tick(2);
   endtask

   task automatic send_code(input logic [7:0] b);
      send_frame(b, odd_par(b), 1'b1, 1'b0);
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ps2c = 1'b1;
      ps2d = 1'b1;
      rd_en = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({valid, code, ext, brk, count, last_code, parity_err, frame_err, overflow} !== 25'd0)
         $display("FAIL reset_outputs: got %h expected 0",
                  {valid, code, ext, brk, count, last_code, parity_err, frame_err, overflow});
      else n_pass++;
   endtask

   task automatic test_basic();
      do_reset();
      send_code(8'h1C);
      n_total++; if (valid !== 1'b1)    $display("FAIL basic_valid: got %b expected 1", valid);      else n_pass++;
      n_total++; if (code !== 8'h1C)    $display("FAIL basic_code: got %h expected 1c", code);       else n_pass++;
      n_total++; if ({ext, brk} !== 2'b00) $display("FAIL basic_flags: got %b expected 00", {ext, brk}); else n_pass++;
      n_total++; if (count !== 4'd1)    $display("FAIL basic_count: got %0d expected 1", count);     else n_pass++;
      n_total++; if (last_code !== 8'h1C) $display("FAIL basic_last: got %h expected 1c", last_code); else n_pass++;
      pop1();
      n_total++; if (valid !== 1'b0)    $display("FAIL basic_pop_valid: got %b expected 0", valid);  else n_pass++;
      n_total++; if (code !== 8'h00)    $display("FAIL basic_pop_code: got %h expected 00", code);   else n_pass++;
      pop1();
      n_total++; if (count !== 4'd0)    $display("FAIL basic_empty_pop: got %0d expected 0", count); else n_pass++;
   endtask

   task automatic test_prefix();
      do_reset();
      send_code(8'hF0);
      n_total++; if (count !== 4'd0)    $display("FAIL prefix_f0_alone: got %0d expected 0", count); else n_pass++;
      send_code(8'h1C);
      n_total++; if (count !== 4'd1)    $display("FAIL prefix_brk_count: got %0d expected 1", count); else n_pass++;
      n_total++; if ({ext, brk, code} !== 10'b01_0001_1100)
         $display("FAIL prefix_brk_entry: got %b expected 0100011100", {ext, brk, code}); else n_pass++;
      pop1();
      send_code(8'hE0);
      send_code(8'hF0);
      send_code(8'h75);
      n_total++; if (count !== 4'd1)    $display("FAIL prefix_ext_count: got %0d expected 1", count); else n_pass++;
      n_total++; if ({ext, brk, code} !== 10'b11_0111_0101)
         $display("FAIL prefix_ext_entry: got %b expected 1101110101", {ext, brk, code}); else n_pass++;
      n_total++; if (last_code !== 8'h75) $display("FAIL prefix_last: got %h expected 75", last_code); else n_pass++;
      pop1();
      send_code(8'h1C);
      n_total++; if ({ext, brk} !== 2'b00) $display("FAIL prefix_cleared: got %b expected 00", {ext, brk}); else n_pass++;
   endtask

   task automatic test_parity();
      int pe0, fe0;
      do_reset();
      pe0 = pe_cnt;
      fe0 = fe_cnt;
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      n_total++; if (pe_cnt - pe0 !== 1) $display("FAIL parity_pulse: got %0d expected 1", pe_cnt - pe0); else n_pass++;
      n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL parity_no_frame_err: got %0d expected 0", fe_cnt - fe0); else n_pass++;
      n_total++; if (count !== 4'd0)     $display("FAIL parity_count: got %0d expected 0", count); else n_pass++;
      n_total++; if (last_code !== 8'h00) $display("FAIL parity_last: got %h expected 00", last_code); else n_pass++;
      n_total++; if (np_count !== 4'd1)  $display("FAIL noparity_count: got %0d expected 1", np_count); else n_pass++;
      n_total++; if (np_code !== 8'h1C)  $display("FAIL noparity_code: got %h expected 1c", np_code); else n_pass++;
   endtask

   task automatic test_stop_bit();
      int fe0;
      do_reset();
      fe0 = fe_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL stop_pulse: got %0d expected 1", fe_cnt - fe0); else n_pass++;
      n_total++; if (count !== 4'd0)     $display("FAIL stop_count: got %0d expected 0", count); else n_pass++;
   endtask

   task automatic test_timeout();
      int fe0;
      logic [10:0] fr;
      do_reset();
      fe0 = fe_cnt;
      fr = {1'b1, 1'b0, 8'h1C, 1'b0};
      for (int i = 0; i < 5; i++) send_bit(fr[i], 1'b0);
      tick(150);
      n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL timeout_early: got %0d expected 0", fe_cnt - fe0); else n_pass++;
      tick(100);
      n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL timeout_pulse: got %0d expected 1", fe_cnt - fe0); else n_pass++;
      n_total++; if (count !== 4'd0)     $display("FAIL timeout_count: got %0d expected 0", count); else n_pass++;
      send_code(8'h1C);
      n_total++; if ({count, code} !== {4'd1, 8'h1C})
         $display("FAIL timeout_recover: got %h expected 11c", {count, code}); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int ov0;
      logic [7:0] exp;
      do_reset();
      ov0 = ov_cnt;
      for (int i = 1; i <= 8; i++) send_code(8'(i));
      n_total++; if (count !== 4'd8)     $display("FAIL fill_count: got %0d expected 8", count); else n_pass++;
      n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL fill_no_overflow: got %0d expected 0", ov_cnt - ov0); else n_pass++;
      send_code(8'h09);
      n_total++; if (ov_cnt - ov0 !== 1) $display("FAIL overflow_pulse: got %0d expected 1", ov_cnt - ov0); else n_pass++;
      n_total++; if (count !== 4'd8)     $display("FAIL overflow_count: got %0d expected 8", count); else n_pass++;
      n_total++; if (last_code !== 8'h09) $display("FAIL overflow_last: got %h expected 09", last_code); else n_pass++;
      n_total++; if (code !== 8'h01)     $display("FAIL overflow_head: got %h expected 01", code); else n_pass++;
      send_frame(8'h0A, odd_par(8'h0A), 1'b1, 1'b1);
      n_total++; if (count !== 4'd8)     $display("FAIL pushpop_count: got %0d expected 8", count); else n_pass++;
      n_total++; if (code !== 8'h02)     $display("FAIL pushpop_head: got %h expected 02", code); else n_pass++;
      n_total++; if (ov_cnt - ov0 !== 1) $display("FAIL pushpop_no_overflow: got %0d expected 1", ov_cnt - ov0); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 8'(i + 2) : 8'h0A;
         n_total++; if (code !== exp) $display("FAIL drain_%0d: got %h expected %h", i, code, exp); else n_pass++;
         pop1();
      end
      n_total++; if (valid !== 1'b0)     $display("FAIL drain_empty: got %b expected 0", valid); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [10:0] fr;
      do_reset();
      send_code(8'h2A);
      fr = {1'b1, 1'b0, 8'h1C, 1'b0};
      for (int i = 0; i < 6; i++) send_bit(fr[i], 1'b0);
      ps2d = fr[6];
      tick(4);
      ps2c = 1'b0;
      tick(3);
      rst = 1'b1;
      #1;
      n_total++;
      if ({valid, code, ext, brk, count, last_code, parity_err, frame_err, overflow} !== 25'd0)
         $display("FAIL midreset_outputs: got %h expected 0",
                  {valid, code, ext, brk, count, last_code, parity_err, frame_err, overflow});
      else n_pass++;
      tick(2);
      ps2c = 1'b1;
      ps2d = 1'b1;
      rst = 1'b0;
      tick(20);
      send_code(8'h1C);
      n_total++; if ({count, code, ext, brk} !== {4'd1, 8'h1C, 2'b00})
         $display("FAIL midreset_recover: got %h expected %h", {count, code, ext, brk}, {4'd1, 8'h1C, 2'b00}); else n_pass++;
      n_total++; if (last_code !== 8'h1C) $display("FAIL midreset_last: got %h expected 1c", last_code); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prefix();
      test_parity();
      test_stop_bit();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Parametrised PS/2 keyboard receiver. Successor to the single-byte PS/2 capture block.
- Adds odd-parity checking, a framing-timeout watchdog, and E0/F0 prefix decoding into make/break and extended flags.
- Buffers decoded scan codes in a FIFO so the CPU-side I/O logic reads keys at its own pace without losing bytes.
- Sits between the board PS/2 pins and the processor input port.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on PS2_clk and PS2_DAT; minimum 2.
- FIFO_DEPTH, 8: decoded-key entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted; minimum 2.
- CHECK_PARITY, 1: 1 = discard bytes with bad odd parity; 0 = ignore the parity bit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- PS2_clk  in  1  raw PS/2 clock
- PS2_DAT  in  1  raw PS/2 data
- rd_en  in  1  pop FIFO head this cycle
- valid  out  1  FIFO not empty
- code  out  8  scan code at FIFO head; 0 when empty
- ext  out  1  head entry was E0-prefixed; 0 when empty
- brk  out  1  head entry was F0-prefixed (key release); 0 when empty
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- last_code  out  8  most recent non-prefix code accepted, whether or not it was pushed
- parity_err  out  1  one-cycle pulse
- frame_err  out  1  one-cycle pulse (bad stop bit or timeout)
- overflow  out  1  one-cycle pulse when a decoded key is dropped because the FIFO is full

Behaviour:
- Reset (async, rst=1):
  - Sync chains and edge-detect previous-value register go to 1 (bus idle).
  - FSM goes to IDLE; FIFO is emptied; pending ext/brk flags are cleared.
  - All outputs are 0.
- Falling edge is detected when prev=1 and the synchronised clock is 0. Data is sampled from the synchronised PS2_DAT in the same cycle.
- Frame FSM advances only on a detected falling edge, except for the timeout:
  - IDLE: data=0 -> DATA with bit_cnt=0 and shift register cleared; data=1 -> stay in IDLE.
  - DATA: store bit into shreg[bit_cnt] (LSB first) and increment. After bit 7 is stored -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: evaluate the byte (see below), then -> IDLE.
- Timeout:
  - Counter is cleared on every falling edge and while in IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE: -> IDLE, frame_err pulses, pending flags are kept.
- Byte evaluation in the STOP cycle:
  - Stop bit = 0: frame_err pulses, byte discarded, pending ext/brk cleared.
  - Else if CHECK_PARITY and XOR(byte, parity) != 1: parity_err pulses, byte discarded, pending flags cleared.
  - Else if byte == 8'hE0: set ext_pend.
  - Else if byte == 8'hF0: set brk_pend.
  - Else:
    - Write {ext_pend, brk_pend, byte} to the FIFO.
    - last_code <= byte.
    - Clear both pending flags.
- Latency: push happens in the clk cycle after the stop-bit edge is detected; valid and count update in the following cycle.
- FIFO behaviour:
  - Show-ahead: code/ext/brk present the head entry combinationally from storage whenever valid=1.
  - rd_en while empty is ignored.
  - Push while full with no pop in the same cycle: the entry is dropped, overflow pulses, last_code still updates.
  - Push and pop in the same cycle while full: both succeed; count is unchanged.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; count saturates naturally at FIFO_DEPTH.
- At most one error pulse is asserted per cycle.
- rst mid-frame aborts the frame; the partial byte is lost.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0.
  - Entry typedef {ext, brk, code[7:0]}.
- One sub-module: ps2_code_fifo, a synchronous show-ahead FIFO, width 10, depth FIFO_DEPTH, same clk/rst.

Test Plan:
- Send frame 0x1C (parity 0, stop 1) -> valid=1, code=0x1C, ext=0, brk=0, count=1, last_code=0x1C; rd_en for 1 cycle -> valid=0, code=0.
- Send F0 then 1C -> exactly one entry, code=0x1C, brk=1, ext=0. Then send E0, F0, 75 -> one entry, code=0x75, ext=1, brk=1.
- Send 0x1C with parity=1 -> parity_err one-cycle pulse, count unchanged. Repeat with CHECK_PARITY=0 -> entry pushed.
- Stop after 4 data bits and hold PS2_clk high for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. Next full 0x1C frame is received correctly.
- With FIFO_DEPTH=8, send 9 codes 0x01..0x09 without reading -> count=8, overflow pulse on the 9th, last_code=0x09, head code=0x01. Then assert rd_en on the cycle the 9th push occurs -> both succeed, count stays 8, head becomes 0x02.
- Assert rst during the bit-5 edge of a frame -> all outputs 0 immediately. Subsequent 0x1C frame decodes correctly.
